// File: rtl/demux_seq_ctrl_pkg.sv
// Shared types and constants for the 1-to-4 demux sequencer.
package demux_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic       MODE_SCAN = 1'b0;
    localparam logic       MODE_DIR  = 1'b1;
    localparam logic [2:0] SCAN_LAST = 3'd7;

    function automatic logic [3:0] dst_onehot(input logic [1:0] dst);
        return 4'b0001 << dst;
    endfunction

endpackage

// File: rtl/demux_seq_ctrl_if.sv
// Request stream and demux-side outputs of the sequencer.
interface demux_seq_ctrl_if #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
);
    logic              mode;
    logic              en;
    logic              req_vld;
    logic [1:0]        req_dst;
    logic [DATA_W-1:0] req_dat;
    logic              req_rdy;
    logic              sel_a;
    logic              sel_b;
    logic [DATA_W-1:0] dmx_o;
    logic [3:0]        out_vld;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (
        output mode, en, req_vld, req_dst, req_dat,
        input  req_rdy, sel_a, sel_b, dmx_o, out_vld, busy, done, xfer_cnt
    );

    modport slave (
        input  mode, en, req_vld, req_dst, req_dat,
        output req_rdy, sel_a, sel_b, dmx_o, out_vld, busy, done, xfer_cnt
    );
endinterface

// File: rtl/demux_seq_ctrl_hold_timer.sv
// Down-counter that times the DRIVE phase; reloads whenever not counting.
module demux_seq_ctrl_hold_timer #(
    parameter int HOLD_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);
    localparam int TW = $clog2(HOLD_CYC + 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (load)         cnt <= TW'(HOLD_CYC - 1);
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    // High on the last of the HOLD_CYC counting cycles.
    assign expire = !load && (cnt == '0);
endmodule

// File: rtl/demux_seq_ctrl.sv
// Sequencer for a combinational 1-to-4 demux: directed request stream or
// self-timed scan of all 8 {a,b,o} codes, with one-hot output strobe.
module demux_seq_ctrl
    import demux_seq_ctrl_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_seq_ctrl_if.slave  bus
);
    state_t            state;
    logic              mode_q;
    logic [2:0]        step;
    logic [2:0]        nxt_step;
    logic [1:0]        sel;
    logic [DATA_W-1:0] dmx_o;
    logic [3:0]        out_vld;
    logic              done;
    logic [CNT_W-1:0]  xfer_cnt;
    logic              expire;

    demux_seq_ctrl_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state != DRIVE),
        .expire (expire)
    );

    assign nxt_step     = step + 3'd1;
    assign bus.req_rdy  = ((state == IDLE) && (bus.mode == MODE_DIR)) ||
                          ((state == GAP)  && (mode_q   == MODE_DIR));
    assign bus.sel_a    = sel[1];
    assign bus.sel_b    = sel[0];
    assign bus.dmx_o    = dmx_o;
    assign bus.out_vld  = out_vld;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done;
    assign bus.xfer_cnt = xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_q   <= MODE_SCAN;
            step     <= '0;
            sel      <= '0;
            dmx_o    <= '0;
            out_vld  <= '0;
            done     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mode == MODE_DIR) begin
                        mode_q <= MODE_DIR;
                        if (bus.req_vld) begin
                            sel     <= bus.req_dst;
                            dmx_o   <= bus.req_dat;
                            out_vld <= dst_onehot(bus.req_dst);
                            state   <= DRIVE;
                        end
                    end else if (bus.en) begin
                        mode_q  <= MODE_SCAN;
                        step    <= '0;
                        sel     <= 2'b00;
                        dmx_o   <= '0;
                        out_vld <= dst_onehot(2'b00);
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (expire) begin
                        // Data forced low between transfers so the demux never glitches.
                        state    <= GAP;
                        out_vld  <= '0;
                        dmx_o    <= '0;
                        xfer_cnt <= xfer_cnt + 1'b1;
                        done     <= (mode_q == MODE_SCAN) && (step == SCAN_LAST);
                    end
                end
                GAP: begin
                    if (mode_q == MODE_DIR) begin
                        if (bus.req_vld) begin
                            sel     <= bus.req_dst;
                            dmx_o   <= bus.req_dat;
                            out_vld <= dst_onehot(bus.req_dst);
                            state   <= DRIVE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (step != SCAN_LAST) begin
                        step    <= nxt_step;
                        sel     <= nxt_step[2:1];
                        dmx_o   <= {DATA_W{nxt_step[0]}};
                        out_vld <= dst_onehot(nxt_step[2:1]);
                        state   <= DRIVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_demux_seq_ctrl.sv
// Randomized bench for demux_seq_ctrl against a transfer-schedule reference model.
module tb_demux_seq_ctrl;
    localparam int DATA_W   = 1;
    localparam int HOLD_CYC = 2;
    localparam int CNT_W    = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_seq_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    demux_seq_ctrl #(.DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 1-to-4 demux fed by the sequencer.
    logic [DATA_W-1:0] dmx_y [4];
    always_comb begin
        for (int i = 0; i < 4; i++)
            dmx_y[i] = (int'({bus.sel_a, bus.sel_b}) == i) ? bus.dmx_o : '0;
    end

    // One entry per expected busy cycle: HOLD_CYC drive slots then one gap slot.
    typedef struct {
        logic              gap;
        logic              dir;
        logic [1:0]        dst;
        logic [DATA_W-1:0] dat;
        logic              last;
    } slot_t;

    slot_t       sched[$];
    int          nvec = 0;
    int          nbad = 0;
    int unsigned cnt_exp = 0;
    int          busy_obs = 0;
    int          done_obs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_xfer(input logic dir, input logic [1:0] dst,
                            input logic [DATA_W-1:0] dat, input logic last);
        slot_t s;
        s.dir = dir; s.dst = dst; s.dat = dat;
        s.gap = 1'b0; s.last = 1'b0;
        for (int i = 0; i < HOLD_CYC; i++) sched.push_back(s);
        s.gap = 1'b1; s.last = last;
        sched.push_back(s);
    endtask

    // Check one cycle at the falling edge, advance the model, return just after the rising edge.
    task automatic cyc();
        slot_t s;
        logic  idle;
        logic  rdy_exp;
        logic [2:0] kk;
        @(negedge clk);
        if (bus.busy) busy_obs++;
        if (bus.done) done_obs++;
        idle = (sched.size() == 0);
        if (idle) begin
            rdy_exp = bus.mode;
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_out_vld", 32'(bus.out_vld), 32'd0);
            chk("idle_dmx_o", 32'(bus.dmx_o), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
        end else begin
            s = sched.pop_front();
            chk("busy", 32'(bus.busy), 32'd1);
            chk("sel", 32'({bus.sel_a, bus.sel_b}), 32'(s.dst));
            if (s.gap) begin
                cnt_exp = (cnt_exp + 1) % (1 << CNT_W);
                rdy_exp = s.dir;
                chk("gap_out_vld", 32'(bus.out_vld), 32'd0);
                chk("gap_dmx_o", 32'(bus.dmx_o), 32'd0);
                chk("gap_done", 32'(bus.done), 32'(s.last));
            end else begin
                rdy_exp = 1'b0;
                chk("drv_out_vld", 32'(bus.out_vld), 32'(1 << s.dst));
                chk("drv_dmx_o", 32'(bus.dmx_o), 32'(s.dat));
                chk("demux_lane", 32'(dmx_y[s.dst]), 32'(s.dat));
                chk("drv_done", 32'(bus.done), 32'd0);
            end
        end
        chk("req_rdy", 32'(bus.req_rdy), 32'(rdy_exp));
        chk("xfer_cnt", 32'(bus.xfer_cnt), cnt_exp);
        if (rdy_exp && bus.req_vld) begin
            add_xfer(1'b1, bus.req_dst, bus.req_dat, 1'b0);
        end else if (idle && !bus.mode && bus.en) begin
            for (int k = 0; k < 8; k++) begin
                kk = 3'(k);
                add_xfer(1'b0, kk[2:1], {DATA_W{kk[0]}}, k == 7);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.mode    = ($urandom_range(0, 3) != 0);
        bus.en      = ($urandom_range(0, 7) == 0);
        bus.req_vld = $urandom_range(0, 1);
        bus.req_dst = 2'($urandom_range(0, 3));
        bus.req_dat = DATA_W'($urandom);
    endtask

    initial begin
        logic found;
        rst_n       = 1'b0;
        bus.mode    = 1'b0;
        bus.en      = 1'b0;
        bus.req_vld = 1'b0;
        bus.req_dst = '0;
        bus.req_dat = '0;
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_sel", 32'({bus.sel_a, bus.sel_b}), 32'd0);
        chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed single transfer to C with data 1.
        bus.mode = 1'b1; bus.req_vld = 1'b1; bus.req_dst = 2'd2; bus.req_dat = 1'b1;
        cyc();
        bus.req_vld = 1'b0;
        repeat (4) cyc();

        // Back-to-back: D then A with req_vld held.
        bus.req_vld = 1'b1; bus.req_dst = 2'd3; bus.req_dat = 1'b1;
        cyc();
        bus.req_dst = 2'd0; bus.req_dat = 1'b0;
        repeat (3) cyc();
        bus.req_vld = 1'b0;
        repeat (4) cyc();

        // Scan with request noise that must be ignored.
        busy_obs = 0; done_obs = 0;
        bus.mode = 1'b0; bus.en = 1'b1;
        cyc();
        bus.en = 1'b0; bus.req_vld = 1'b1;
        repeat (26) cyc();
        bus.req_vld = 1'b0;
        chk("scan_busy_cycles", 32'(busy_obs), 32'd24);
        chk("scan_done_pulses", 32'(done_obs), 32'd1);

        // en asserted during a directed transfer.
        bus.mode = 1'b1; bus.req_vld = 1'b1; bus.req_dst = 2'd1;
        cyc();
        bus.req_vld = 1'b0; bus.en = 1'b1;
        repeat (4) cyc();
        bus.en = 1'b0;

        // Random traffic, including mode flips while busy.
        repeat (400) begin
            rand_inputs();
            cyc();
        end
        bus.req_vld = 1'b0; bus.en = 1'b0; bus.mode = 1'b1;
        repeat (30) cyc();

        // Counter wrap: 256+ back-to-back directed transfers.
        bus.mode = 1'b1; bus.req_vld = 1'b1;
        repeat (256 * (HOLD_CYC + 1) + 6) begin
            bus.req_dst = 2'($urandom_range(0, 3));
            bus.req_dat = DATA_W'($urandom);
            cyc();
        end
        bus.req_vld = 1'b0;
        repeat (4) cyc();

        // Asynchronous reset in the middle of a transfer to C.
        bus.req_vld = 1'b1; bus.req_dst = 2'd2; bus.req_dat = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (bus.out_vld != 4'b0000) found = 1'b1;
        end
        chk("t1_reach_drive", 32'(found), 32'd1);
        chk("t1_pre_out_vld", 32'(bus.out_vld), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_out_vld", 32'(bus.out_vld), 32'd0);
        chk("t1_sel", 32'({bus.sel_a, bus.sel_b}), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        chk("t1_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
        sched.delete();
        cnt_exp = 0;
        bus.req_vld = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc();
        bus.req_vld = 1'b1; bus.req_dst = 2'd1; bus.req_dat = 1'b0;
        cyc();
        bus.req_vld = 1'b0;
        repeat (5) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
